cpu_intc: RTL and testbench
===========================

Name: cpu_intc

Overview:
- Interrupt controller on the CPU's peripheral bus. It is the requesting end of the fetch stage's interrupt handshake: it drives `int` and consumes `int_ack`.
- It latches edge events from NSRC sources, applies per-source masks and a global enable, and requests the CPU.
- On `int_ack` it auto-clears the global enable, so the CPU never sees a nested request.
- It holds the handler vector that software reads into $iv.

Parameters:
- NSRC, 8, number of interrupt sources (legal range 1..31).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  bus select for this block, one-cycle access.
- we  in  1  write strobe, qualified by en.
- addr  in  32  byte address; only addr[3:2] is decoded.
- din  in  32  write data.
- dout  out  32  read data, registered.
- irq_in  in  NSRC  raw source lines, active-high.
- int  out  1  interrupt request to the fetch stage.
- int_ack  in  1  fetch-stage acknowledge; high while injecting, low when idle.
- int_vec  out  32  handler vector register contents.

Behaviour:
- Register map, decoded by addr[3:2]:
  - 0: MASK. Bit0 = GIE; bit i+1 = enable for source i; unused bits read 0.
  - 1: STATUS. Bit i+1 = pending for source i. Write-1-to-clear. Bit0 reads 0.
  - 2: VECTOR. Full 32-bit read/write, drives int_vec.
  - 3: reads 0, writes ignored.
- Reads: when en && !we, dout is updated on the next clk edge. Otherwise dout holds its value.
- Writes: take effect on the clk edge where en && we.
- Reset (asynchronous): MASK=0, STATUS=0, VECTOR=0, dout=0, int=0, edge-history register=0, FSM=IDLE.
- Edge capture: the edge-history register samples irq_in every cycle. The pending bit is set when the current sample is 1 and the previous sample is 0.
  - Capture happens regardless of mask or GIE.
  - A level held high sets pending only once.
- Same-cycle set and W1C of the same pending bit: set wins, and the bit stays 1.
- Request condition: req = GIE & |(STATUS[NSRC:1] & MASK[NSRC:1]).
- FSM:
  - IDLE, int=0: go to REQ when req=1.
  - REQ, int=1: hold until int_ack=1. Then clear GIE on that edge and go to ACK.
    - Software writes to MASK or STATUS during REQ do not withdraw int; the CPU may already be committed.
  - ACK, int=0: hold until int_ack=0, then go to IDLE.
    - GIE stays 0 until software sets it. Pending bits are not touched by the FSM.
- Latency without sync: an irq_in rising edge at clock edge N sets pending at edge N. int asserts after edge N+1, provided GIE and the mask bit are set.
- Software GIE write in the same cycle that int_ack rises: the hardware clear wins.
- int_ack high while in IDLE (spurious): ignored, and no state change.
- Reset asserted mid-handshake: immediately returns to IDLE with int=0 and all registers cleared.

Optional Feature:
- Macro: CPU_INTC_SYNC_EN.
- Defined: each irq_in bit passes through a 2-flop synchronizer before the edge-history register. Synchronizer flops reset to 0. This adds 2 cycles of latency to pending.
- Undefined: irq_in feeds edge detection directly, and sources must be clk-synchronous.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle, then read MASK, STATUS and VECTOR → all 0, int=0, int_vec=0.
2. Basic request, sync off:
   - Setup: write MASK=0x3 (GIE plus source 0); pulse irq_in[0] for 1 cycle.
   - Response: STATUS=0x2. int goes high 1 cycle after pending.
   - Then raise int_ack: int drops the next cycle and MASK reads 0x2.
   - Then drop int_ack: FSM returns to IDLE.
3. Masked source: MASK=0x1, pulse irq_in[3] → STATUS=0x10 and int stays 0. Then write MASK=0x11 → int=1 the following cycle.
4. Clear race: hold STATUS bit1 set, then write STATUS=0x2 in the same cycle as a new irq_in[0] rising edge → STATUS still reads 0x2.
5. No nesting: during ACK, pulse irq_in[1] with MASK bit2 set → pending sets but int stays 0. After software writes GIE=1 → int=1.
6. Vector and sync, with CPU_INTC_SYNC_EN defined:
   - Write VECTOR=0x00001000 → int_vec=0x00001000 on the next cycle.
   - An irq_in edge sets pending exactly 2 cycles later than the same stimulus without the macro.

Source files
------------

// File: rtl/cpu_intc.sv
// CPU interrupt controller: edge-captured sources, per-source masks, global enable
// auto-cleared on acknowledge, and a handler vector. Optional macro: CPU_INTC_SYNC_EN.
module cpu_intc #(
  parameter int NSRC = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     din_i,
  output logic [31:0]     dout_o,
  input  logic [NSRC-1:0] irq_in_i,
  output logic            int_o,
  input  logic            int_ack_i,
  output logic [31:0]     int_vec_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC:0]   mask_q, mask_d;
  logic [NSRC:0]   status_q, status_d;
  logic [31:0]     vector_q, vector_d;
  logic [31:0]     dout_q, dout_d;
  logic            int_q, int_d;
  logic [NSRC-1:0] hist_q;
  logic [NSRC-1:0] irq_s;
  logic [NSRC-1:0] rise_s;
  logic            wr_s, rd_s, req_s, gie_clr_s;
  logic [1:0]      sel_s;
  logic [31:0]     rdata_s;
  logic            unused_addr_s;

  assign unused_addr_s = ^{addr_i[31:4], addr_i[1:0]};

`ifdef CPU_INTC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous source lines
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in_i;
`endif

  // Bus decode, edge detection and request qualification
  always_comb begin
    wr_s   = en_i & we_i;
    rd_s   = en_i & ~we_i;
    sel_s  = addr_i[3:2];
    rise_s = irq_s & ~hist_q;
    req_s  = mask_q[0] & (|(status_q[NSRC:1] & mask_q[NSRC:1]));
  end

  // Handshake FSM: a committed request is never withdrawn by software
  always_comb begin
    state_d   = state_q;
    gie_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) state_d = REQ;
        else       state_d = IDLE;
      end
      REQ: begin
        if (int_ack_i) begin
          state_d   = ACK;
          gie_clr_s = 1'b1;
        end else begin
          state_d   = REQ;
        end
      end
      ACK: begin
        if (!int_ack_i) state_d = IDLE;
        else            state_d = ACK;
      end
      default: state_d = IDLE;
    endcase
    int_d = (state_d == REQ);
  end

  // Register file next state; a new edge beats a same-cycle clear, hardware GIE clear beats software
  always_comb begin
    mask_d   = mask_q;
    status_d = status_q;
    vector_d = vector_q;
    if (wr_s && (sel_s == 2'd0)) mask_d = din_i[NSRC:0];
    else                         mask_d = mask_q;
    if (gie_clr_s) mask_d[0] = 1'b0;
    else           mask_d[0] = mask_d[0];
    if (wr_s && (sel_s == 2'd1)) status_d = status_q & ~din_i[NSRC:0];
    else                         status_d = status_q;
    status_d[NSRC:1] = status_d[NSRC:1] | rise_s;
    status_d[0]      = 1'b0;
    if (wr_s && (sel_s == 2'd2)) vector_d = din_i;
    else                         vector_d = vector_q;
  end

  // Read mux, sampled into dout only on a read access
  always_comb begin
    rdata_s = 32'd0;
    case (sel_s)
      2'd0:    rdata_s[NSRC:0] = mask_q;
      2'd1:    rdata_s[NSRC:0] = status_q;
      2'd2:    rdata_s = vector_q;
      default: rdata_s = 32'd0;
    endcase
    if (rd_s) dout_d = rdata_s;
    else      dout_d = dout_q;
  end

  // State and register update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      status_q <= '0;
      vector_q <= 32'd0;
      dout_q   <= 32'd0;
      int_q    <= 1'b0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      vector_q <= vector_d;
      dout_q   <= dout_d;
      int_q    <= int_d;
      hist_q   <= irq_s;
    end
  end

  assign dout_o    = dout_q;
  assign int_o     = int_q;
  assign int_vec_o = vector_q;

endmodule

// File: tb/tb_cpu_intc.sv
// Directed self-checking bench for cpu_intc (default build; honours CPU_INTC_SYNC_EN).
module tb_cpu_intc;

`ifdef CPU_INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, we = 1'b0, int_ack = 1'b0;
  logic [31:0] addr = 32'd0, din = 32'd0;
  logic [31:0] dout, int_vec;
  logic [7:0]  irq = 8'd0;
  logic        int_s;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] rd;

  cpu_intc #(.NSRC(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
    .dout_o(dout), .irq_in_i(irq), .int_o(int_s), .int_ack_i(int_ack), .int_vec_o(int_vec)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); en = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk); en = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); en = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); en = 1'b0; d = dout;
  endtask

  task automatic pulse(input int idx);
    @(negedge clk); irq[idx] = 1'b1;
    @(negedge clk); irq[idx] = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  task automatic handshake;
    @(negedge clk); int_ack = 1'b1;
    @(negedge clk); int_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_write(32'h0, 32'hFFFF_FFFF);
    bus_read(32'h0, rd);
    total_cnt++; if (rd !== 32'h0000_01FF) $display("FAIL mask_unused: got %h exp %h", rd, 32'h1FF); else pass_cnt++;
    bus_write(32'h8, 32'hA5A5_5A5A);
    total_cnt++; if (dout !== 32'h0000_01FF) $display("FAIL dout_hold: got %h exp %h", dout, 32'h1FF); else pass_cnt++;
    @(posedge clk); #3 rst = 1'b1; #1;
    total_cnt++; if (int_vec !== 32'h0) $display("FAIL rst_vec: got %h exp %h", int_vec, 32'h0); else pass_cnt++;
    total_cnt++; if (int_s !== 1'b0) $display("FAIL rst_int: got %b exp 0", int_s); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    bus_read(32'h0, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL rst_mask: got %h exp %h", rd, 32'h0); else pass_cnt++;
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL rst_status: got %h exp %h", rd, 32'h0); else pass_cnt++;
    bus_read(32'h8, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL rst_vector: got %h exp %h", rd, 32'h0); else pass_cnt++;
  endtask

  task automatic test_basic;
    bus_write(32'h0, 32'h3);
    pulse(0);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL basic_int_early: got %b exp 0", int_s); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (int_s !== 1'b1) $display("FAIL basic_int: got %b exp 1", int_s); else pass_cnt++;
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h2) $display("FAIL basic_status: got %h exp %h", rd, 32'h2); else pass_cnt++;
    int_ack = 1'b1;
    @(negedge clk);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL basic_ack_drop: got %b exp 0", int_s); else pass_cnt++;
    bus_read(32'h0, rd);
    total_cnt++; if (rd !== 32'h2) $display("FAIL basic_gie_clr: got %h exp %h", rd, 32'h2); else pass_cnt++;
    int_ack = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL basic_idle: got %b exp 0", int_s); else pass_cnt++;
    bus_write(32'h4, 32'h2);
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL w1c: got %h exp %h", rd, 32'h0); else pass_cnt++;
  endtask

  task automatic test_masked;
    bus_write(32'h0, 32'h1);
    pulse(3);
    repeat (2) @(negedge clk);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL masked_int: got %b exp 0", int_s); else pass_cnt++;
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h10) $display("FAIL masked_status: got %h exp %h", rd, 32'h10); else pass_cnt++;
    bus_write(32'h0, 32'h11);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL unmask_early: got %b exp 0", int_s); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (int_s !== 1'b1) $display("FAIL unmask_int: got %b exp 1", int_s); else pass_cnt++;
    handshake();
    bus_write(32'h4, 32'h10);
  endtask

  task automatic test_clear_race;
    pulse(0);
    @(negedge clk); irq[0] = 1'b1;
    repeat (LAT) @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 32'h4; din = 32'h2;
    @(negedge clk); en = 1'b0; we = 1'b0; irq[0] = 1'b0;
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h2) $display("FAIL race_set_wins: got %h exp %h", rd, 32'h2); else pass_cnt++;
    @(negedge clk); irq[0] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    bus_write(32'h4, 32'h2);
    repeat (3) @(negedge clk);
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL level_once: got %h exp %h", rd, 32'h0); else pass_cnt++;
    irq[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_nesting;
    bus_write(32'h0, 32'h5);
    pulse(1);
    @(negedge clk);
    total_cnt++; if (int_s !== 1'b1) $display("FAIL nest_req: got %b exp 1", int_s); else pass_cnt++;
    int_ack = 1'b1;
    @(negedge clk);
    bus_write(32'h4, 32'h4);
    pulse(1);
    repeat (2) @(negedge clk);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL nest_blocked: got %b exp 0", int_s); else pass_cnt++;
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h4) $display("FAIL nest_pending: got %h exp %h", rd, 32'h4); else pass_cnt++;
    int_ack = 1'b0;
    @(negedge clk);
    bus_write(32'h0, 32'h5);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL regie_early: got %b exp 0", int_s); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (int_s !== 1'b1) $display("FAIL regie_int: got %b exp 1", int_s); else pass_cnt++;
    @(negedge clk);
    int_ack = 1'b1; en = 1'b1; we = 1'b1; addr = 32'h0; din = 32'h5;
    @(negedge clk); en = 1'b0; we = 1'b0;
    total_cnt++; if (int_s !== 1'b0) $display("FAIL gie_race_int: got %b exp 0", int_s); else pass_cnt++;
    bus_read(32'h0, rd);
    total_cnt++; if (rd !== 32'h4) $display("FAIL gie_race_hw_wins: got %h exp %h", rd, 32'h4); else pass_cnt++;
    int_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spurious_ack;
    @(negedge clk); int_ack = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL spur_idle: got %b exp 0", int_s); else pass_cnt++;
    bus_write(32'h0, 32'h5);
    @(negedge clk);
    total_cnt++; if (int_s !== 1'b1) $display("FAIL spur_req: got %b exp 1", int_s); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (int_s !== 1'b0) $display("FAIL spur_ack: got %b exp 0", int_s); else pass_cnt++;
    int_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector;
    bus_write(32'h8, 32'h0000_1000);
    total_cnt++; if (int_vec !== 32'h0000_1000) $display("FAIL int_vec: got %h exp %h", int_vec, 32'h1000); else pass_cnt++;
    bus_read(32'h8, rd);
    total_cnt++; if (rd !== 32'h0000_1000) $display("FAIL vector_rd: got %h exp %h", rd, 32'h1000); else pass_cnt++;
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL reg3: got %h exp %h", rd, 32'h0); else pass_cnt++;
  endtask

  task automatic test_latency;
    int cnt;
    bus_write(32'h4, 32'hFFFF_FFFF);
    bus_write(32'h0, 32'h9);
    @(negedge clk); irq[2] = 1'b1;
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk);
      cnt++;
      irq[2] = 1'b0;
      if (int_s === 1'b1) break;
    end
    total_cnt++; if (cnt !== 2 + LAT) $display("FAIL latency: got %0d cycles exp %0d", cnt, 2 + LAT); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    total_cnt++; if (int_s !== 1'b1) $display("FAIL mid_pre: got %b exp 1", int_s); else pass_cnt++;
    @(posedge clk); #3 rst = 1'b1; #1;
    total_cnt++; if (int_s !== 1'b0) $display("FAIL mid_int: got %b exp 0", int_s); else pass_cnt++;
    total_cnt++; if (int_vec !== 32'h0) $display("FAIL mid_vec: got %h exp %h", int_vec, 32'h0); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    bus_read(32'h4, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL mid_status: got %h exp %h", rd, 32'h0); else pass_cnt++;
    bus_read(32'h0, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL mid_mask: got %h exp %h", rd, 32'h0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_clear_race();
    test_no_nesting();
    test_spurious_ack();
    test_vector();
    test_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
